// File: rtl/phi_mask_controller.sv
// phi_mask_controller: rate-based auto-masking of phi trigger channels.
// Counts scaler rising edges per channel over a fixed window, then walks the
// window snapshot one channel per cycle. Any channel whose count exceeded the
// threshold is masked for HOLDOFF_WINDOWS windows. The auto mask is ORed with
// the software mask.
// Channel order: bits 0..NUM_PHI-1 V-pol, NUM_PHI..2*NUM_PHI-1 H-pol.
// Ports:
//   clk250_i, rst_n_i         trigger clock, async active-low reset
//   V_pol_phi_sc_i/H_pol_...  scaler pulses per phi sector
//   sw_mask_i                 software mask (1 = masked)
//   threshold_i               channel masks when count > threshold
//   auto_en_i                 gates the auto mask into mask_o
//   rate_addr_i / rate_o      last-window count readout
//   mask_o                    registered mask to the trigger map
//   auto_mask_o, update_o     current auto mask, pulse when it is applied
// Build option: define PHI_MASK_RATE_READOUT_EN to keep full count snapshots
// and the rate_o readout. Otherwise only a per-channel exceed flag is
// snapshotted and rate_o is 0.
module phi_mask_controller #(
    parameter int unsigned NUM_PHI         = 16,
    parameter int unsigned CNT_WIDTH       = 12,
    parameter int unsigned WINDOW_CYCLES   = 250000,
    parameter int unsigned HOLDOFF_WINDOWS = 4
) (
    input  logic                   clk250_i,
    input  logic                   rst_n_i,
    input  logic [NUM_PHI-1:0]     V_pol_phi_sc_i,
    input  logic [NUM_PHI-1:0]     H_pol_phi_sc_i,
    input  logic [2*NUM_PHI-1:0]   sw_mask_i,
    input  logic [CNT_WIDTH-1:0]   threshold_i,
    input  logic                   auto_en_i,
    input  logic [4:0]             rate_addr_i,
    output logic [2*NUM_PHI-1:0]   mask_o,
    output logic [2*NUM_PHI-1:0]   auto_mask_o,
    output logic                   update_o,
    output logic [CNT_WIDTH-1:0]   rate_o
);
    localparam int unsigned NCH   = 2 * NUM_PHI;
    localparam int unsigned IDX_W = $clog2(NCH);
    localparam int unsigned TMR_W = $clog2(WINDOW_CYCLES);
    localparam int unsigned HO_W  = 3;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {IDLE, LATCH, EVAL, APPLY} state_e;

    // Input register and rising-edge detect
    logic [NCH-1:0] in_q, prev_q, rise;

    always_ff @(posedge clk250_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            in_q   <= '0;
            prev_q <= '0;
        end else begin
            in_q   <= {H_pol_phi_sc_i, V_pol_phi_sc_i};
            prev_q <= in_q;
        end
    end

    assign rise = in_q & ~prev_q;

    // Window timer
    logic [TMR_W-1:0] timer_q;
    logic             wrap;

    assign wrap = (timer_q == TMR_W'(WINDOW_CYCLES - 1));

    always_ff @(posedge clk250_i or negedge rst_n_i) begin
        if (!rst_n_i) timer_q <= '0;
        else          timer_q <= wrap ? '0 : timer_q + TMR_W'(1);
    end

    // Saturating per-channel counters; an edge on the wrap cycle starts the new window
    logic [CNT_WIDTH-1:0] cnt_q [NCH];

    always_ff @(posedge clk250_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int unsigned i = 0; i < NCH; i++) cnt_q[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < NCH; i++) begin
                if (wrap)                             cnt_q[i] <= CNT_WIDTH'(rise[i]);
                else if (rise[i] && cnt_q[i] != CNT_MAX) cnt_q[i] <= cnt_q[i] + CNT_WIDTH'(1);
            end
        end
    end

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             eval_exceed;

`ifdef PHI_MASK_RATE_READOUT_EN
    // Full snapshot, shadow threshold sampled in LATCH, registered readout
    logic [CNT_WIDTH-1:0] snap_q [NCH];
    logic [CNT_WIDTH-1:0] thr_q;
    logic [CNT_WIDTH-1:0] rate_q;

    always_ff @(posedge clk250_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int unsigned i = 0; i < NCH; i++) snap_q[i] <= '0;
            thr_q  <= '0;
            rate_q <= '0;
        end else begin
            if (wrap) begin
                for (int unsigned i = 0; i < NCH; i++) snap_q[i] <= cnt_q[i];
            end
            if (state_q == LATCH) thr_q <= threshold_i;
            rate_q <= (32'(rate_addr_i) < NCH) ? snap_q[rate_addr_i[IDX_W-1:0]] : '0;
        end
    end

    assign eval_exceed = (snap_q[idx_q] > thr_q);
    assign rate_o      = rate_q;
`else
    // Exceed flag per channel, decided at the wrap
    logic [NCH-1:0] exc_q;
    logic           unused_rate_addr;

    always_ff @(posedge clk250_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            exc_q <= '0;
        end else if (wrap) begin
            for (int unsigned i = 0; i < NCH; i++) exc_q[i] <= (cnt_q[i] > threshold_i);
        end
    end

    assign eval_exceed      = exc_q[idx_q];
    assign rate_o           = '0;
    assign unused_rate_addr = ^rate_addr_i;
`endif

    // Scan FSM and holdoff bookkeeping
    logic [HO_W-1:0] hold_q [NCH];
    logic [HO_W-1:0] hold_d [NCH];
    logic [HO_W-1:0] hold_new;
    logic [NCH-1:0]  next_auto_q, next_auto_d;
    logic [NCH-1:0]  auto_mask_q, auto_mask_d;
    logic            update_q, update_d;
    logic [NCH-1:0]  mask_q, mask_d;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        hold_d      = hold_q;
        hold_new    = hold_q[idx_q];
        next_auto_d = next_auto_q;
        auto_mask_d = auto_mask_q;
        unique case (state_q)
            IDLE: begin
                if (wrap) state_d = LATCH;
            end
            LATCH: begin
                idx_d   = '0;
                state_d = EVAL;
            end
            EVAL: begin
                if (eval_exceed)               hold_new = HO_W'(HOLDOFF_WINDOWS);
                else if (hold_q[idx_q] != '0)  hold_new = hold_q[idx_q] - HO_W'(1);
                hold_d[idx_q]      = hold_new;
                next_auto_d[idx_q] = (hold_new != '0);
                if (idx_q == IDX_W'(NCH - 1)) state_d = APPLY;
                else                          idx_d   = idx_q + IDX_W'(1);
            end
            APPLY: begin
                auto_mask_d = next_auto_q;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
        update_d = (state_d == APPLY);
        mask_d   = sw_mask_i | (auto_en_i ? auto_mask_q : '0);
    end

    always_ff @(posedge clk250_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            for (int unsigned i = 0; i < NCH; i++) hold_q[i] <= '0;
            next_auto_q <= '0;
            auto_mask_q <= '0;
            update_q    <= 1'b0;
            mask_q      <= '1;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            hold_q      <= hold_d;
            next_auto_q <= next_auto_d;
            auto_mask_q <= auto_mask_d;
            update_q    <= update_d;
            mask_q      <= mask_d;
        end
    end

    assign mask_o      = mask_q;
    assign auto_mask_o = auto_mask_q;
    assign update_o    = update_q;
endmodule

// File: tb/tb_phi_mask_controller.sv
module tb_phi_mask_controller;
    localparam int NP  = 16;
    localparam int NCH = 32;
    localparam int CW  = 4;
    localparam int WC  = 100;
    localparam int HO  = 2;
    localparam int SAT = 15;
`ifdef PHI_MASK_RATE_READOUT_EN
    localparam bit RATE_EN = 1'b1;
`else
    localparam bit RATE_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [NP-1:0] v_sc = '0, h_sc = '0;
    logic [31:0]   sw = '0;
    logic [CW-1:0] thr = 4'd5;
    logic          en = 1'b0;
    logic [4:0]    addr = '0;
    logic [31:0]   mask_o, auto_mask_o;
    logic          update_o;
    logic [CW-1:0] rate_o;

    phi_mask_controller #(
        .NUM_PHI(NP), .CNT_WIDTH(CW), .WINDOW_CYCLES(WC), .HOLDOFF_WINDOWS(HO)
    ) dut (
        .clk250_i(clk), .rst_n_i(rst_n),
        .V_pol_phi_sc_i(v_sc), .H_pol_phi_sc_i(h_sc),
        .sw_mask_i(sw), .threshold_i(thr), .auto_en_i(en), .rate_addr_i(addr),
        .mask_o(mask_o), .auto_mask_o(auto_mask_o), .update_o(update_o), .rate_o(rate_o)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Stimulus schedule: per-window pulse counts plus two special patterns
    int            cnt_sched [NCH];
    bit            wrap16 = 1'b0;
    bit            tog31 = 1'b0;
    logic [CW-1:0] thr_pend = 4'd5;

    // Reference model state (window-level rules)
    int            p;
    int            acc [NCH];
    int            snap_m [NCH];
    int            hold_m [NCH];
    logic [31:0]   pend_m, auto_m, s_prev, rise_pend;
    int            upd_at, apply_at;
    logic [31:0]   exp_mask;
    logic          exp_upd;
    logic [CW-1:0] exp_rate;

    task automatic clear_sched();
        for (int ch = 0; ch < NCH; ch++) cnt_sched[ch] = 0;
    endtask

    task automatic model_reset();
        p = 0;
        for (int ch = 0; ch < NCH; ch++) begin
            acc[ch] = 0; snap_m[ch] = 0; hold_m[ch] = 0;
        end
        pend_m = '0; auto_m = '0; s_prev = '0; rise_pend = '0;
        upd_at = -1; apply_at = -1;
        exp_mask = '1; exp_upd = 1'b0; exp_rate = '0;
    endtask

    // Drive one clock of stimulus, then advance the reference model
    task automatic tick();
        int q, o, c;
        logic [31:0] vec;
        q = p + 1;
        o = q % WC;
        if (o == 10) thr = thr_pend;
        for (int ch = 0; ch < NCH; ch++) begin
            vec[ch] = ((o >= 2) && (o < 2 + 2 * cnt_sched[ch]) && ((o % 2) == 0))
                   || (wrap16 && ch == 16 && o == WC - 1)
                   || (tog31 && ch == 31 && ((q / 2) % 2 == 1));
        end
        v_sc = vec[15:0];
        h_sc = vec[31:16];
        @(posedge clk);
        #1;
        p = q;
        exp_rate = RATE_EN ? CW'(snap_m[addr]) : '0;
        exp_mask = sw | (en ? auto_m : '0);
        if (p == apply_at) auto_m = pend_m;
        exp_upd = (p == upd_at);
        if (p % WC == 0) begin
            for (int ch = 0; ch < NCH; ch++) begin
                c = (acc[ch] > SAT) ? SAT : acc[ch];
                snap_m[ch] = c;
                if (c > int'(thr))      hold_m[ch] = HO;
                else if (hold_m[ch] > 0) hold_m[ch] = hold_m[ch] - 1;
                pend_m[ch] = (hold_m[ch] != 0);
                acc[ch] = 0;
            end
            upd_at   = p + 2 * NP + 1;
            apply_at = p + 2 * NP + 2;
        end
        for (int ch = 0; ch < NCH; ch++) if (rise_pend[ch]) acc[ch]++;
        rise_pend = vec & ~s_prev;
        s_prev    = vec;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; sw = 32'h0001_0002; en = 1'b0; thr = 4'd5; thr_pend = 4'd5; addr = '0;
        clear_sched();
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (mask_o !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL rst_mask got %h exp ffffffff", mask_o); end
        n_cmp++; if (auto_mask_o !== 32'h0) begin n_err++; $display("FAIL rst_auto got %h exp 0", auto_mask_o); end
        n_cmp++; if (update_o !== 1'b0) begin n_err++; $display("FAIL rst_upd got %b exp 0", update_o); end
        n_cmp++; if (rate_o !== 4'h0) begin n_err++; $display("FAIL rst_rate got %h exp 0", rate_o); end
        rst_n = 1'b1;
        tick();
        n_cmp++; if (mask_o !== 32'h0001_0002) begin n_err++; $display("FAIL rel_mask got %h exp 00010002", mask_o); end
    endtask

    task automatic test_exceed_holdoff();
        en = 1'b1;
        for (int ch = 0; ch < NCH; ch++) cnt_sched[ch] = int'($urandom_range(0, 5));
        cnt_sched[3] = 6;
        while (p < 3 * WC + 40) begin
            if (p % WC == 0) begin
                clear_sched();
                if (p == WC) cnt_sched[4] = 5;
            end
            tick();
            n_cmp++; if (update_o !== exp_upd) begin n_err++; $display("FAIL ex_upd p=%0d got %b exp %b", p, update_o, exp_upd); end
            n_cmp++; if (auto_mask_o !== auto_m) begin n_err++; $display("FAIL ex_auto p=%0d got %h exp %h", p, auto_mask_o, auto_m); end
            n_cmp++; if (mask_o !== exp_mask) begin n_err++; $display("FAIL ex_mask p=%0d got %h exp %h", p, mask_o, exp_mask); end
            if (p == 133) begin n_cmp++; if (update_o !== 1'b1) begin n_err++; $display("FAIL ex_upd_time got %b exp 1", update_o); end end
            if (p == 134) begin n_cmp++; if (auto_mask_o !== 32'h8) begin n_err++; $display("FAIL ex_auto0 got %h exp 8", auto_mask_o); end end
            if (p == 135) begin n_cmp++; if (mask_o[3] !== 1'b1) begin n_err++; $display("FAIL ex_mask3 got %b exp 1", mask_o[3]); end end
            if (p == 234) begin n_cmp++; if (auto_mask_o !== 32'h8) begin n_err++; $display("FAIL ho_win1 got %h exp 8", auto_mask_o); end end
            if (p == 334) begin n_cmp++; if (auto_mask_o !== 32'h0) begin n_err++; $display("FAIL ho_expire got %h exp 0", auto_mask_o); end end
        end
    endtask

    task automatic test_wrap_coincidence();
        clear_sched();
        addr = 5'd16;
        wrap16 = 1'b1;
        while (p < 5 * WC + 2) begin
            if (p == 4 * WC) wrap16 = 1'b0;
            tick();
            n_cmp++; if (rate_o !== exp_rate) begin n_err++; $display("FAIL wr_rate p=%0d got %h exp %h", p, rate_o, exp_rate); end
            if (p == 4 * WC + 1) begin n_cmp++; if (rate_o !== 4'd0) begin n_err++; $display("FAIL wr_old got %h exp 0", rate_o); end end
            if (p == 5 * WC + 1) begin
                n_cmp++; if (rate_o !== (RATE_EN ? 4'd1 : 4'd0)) begin n_err++; $display("FAIL wr_new got %h exp %h", rate_o, RATE_EN ? 4'd1 : 4'd0); end
            end
        end
    endtask

    task automatic test_saturation();
        tog31 = 1'b1;
        addr = 5'd31;
        thr_pend = 4'd15;
        while (p < 7 * WC + 36) begin
            if (p == 6 * WC) thr_pend = 4'd14;
            tick();
            n_cmp++; if (rate_o !== exp_rate) begin n_err++; $display("FAIL sat_rate p=%0d got %h exp %h", p, rate_o, exp_rate); end
            n_cmp++; if (auto_mask_o !== auto_m) begin n_err++; $display("FAIL sat_auto p=%0d got %h exp %h", p, auto_mask_o, auto_m); end
            if (p == 6 * WC + 1) begin
                n_cmp++; if (rate_o !== (RATE_EN ? 4'd15 : 4'd0)) begin n_err++; $display("FAIL sat_val got %h exp %h", rate_o, RATE_EN ? 4'd15 : 4'd0); end
            end
            if (p == 634) begin n_cmp++; if (auto_mask_o[31] !== 1'b0) begin n_err++; $display("FAIL sat_thr15 got %b exp 0", auto_mask_o[31]); end end
            if (p == 734) begin n_cmp++; if (auto_mask_o[31] !== 1'b1) begin n_err++; $display("FAIL sat_thr14 got %b exp 1", auto_mask_o[31]); end end
        end
        tog31 = 1'b0;
    endtask

    task automatic test_auto_en_reset();
        en = 1'b0;
        thr_pend = 4'd5;
        sw = $urandom;
        clear_sched();
        while (p < 10 * WC + 15) begin
            if (p % WC == 0) begin
                clear_sched();
                if (p == 8 * WC || p == 9 * WC) cnt_sched[3] = 6;
            end
            tick();
            n_cmp++; if (mask_o !== exp_mask) begin n_err++; $display("FAIL en_mask p=%0d got %h exp %h", p, mask_o, exp_mask); end
            n_cmp++; if (auto_mask_o !== auto_m) begin n_err++; $display("FAIL en_auto p=%0d got %h exp %h", p, auto_mask_o, auto_m); end
            if (p == 935) begin n_cmp++; if (auto_mask_o !== 32'h8) begin n_err++; $display("FAIL en_auto8 got %h exp 8", auto_mask_o); end end
            if (p == 936) begin n_cmp++; if (mask_o !== sw) begin n_err++; $display("FAIL en_off got %h exp %h", mask_o, sw); end end
        end
        // Reset lands in the middle of the channel scan
        rst_n = 1'b0;
        model_reset();
        clear_sched();
        #1;
        n_cmp++; if (auto_mask_o !== 32'h0) begin n_err++; $display("FAIL mr_auto got %h exp 0", auto_mask_o); end
        n_cmp++; if (mask_o !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL mr_mask got %h exp ffffffff", mask_o); end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 95; i++) begin
            tick();
            n_cmp++; if (update_o !== 1'b0) begin n_err++; $display("FAIL mr_upd p=%0d got %b exp 0", p, update_o); end
            n_cmp++; if (auto_mask_o !== 32'h0) begin n_err++; $display("FAIL mr_auto2 p=%0d got %h exp 0", p, auto_mask_o); end
            n_cmp++; if (mask_o !== exp_mask) begin n_err++; $display("FAIL mr_mask2 p=%0d got %h exp %h", p, mask_o, exp_mask); end
        end
    endtask

    task automatic test_random();
        while (p < 9 * WC + 40) begin
            if (p % WC == 0) begin
                for (int ch = 0; ch < NCH; ch++) cnt_sched[ch] = int'($urandom_range(0, 9));
                thr_pend = CW'($urandom_range(2, 9));
                tog31 = ($urandom_range(0, 3) == 0);
            end
            addr = 5'($urandom);
            if ($urandom_range(0, 15) == 0) sw = $urandom;
            if ($urandom_range(0, 15) == 0) en = 1'($urandom);
            tick();
            n_cmp++; if (update_o !== exp_upd) begin n_err++; $display("FAIL rnd_upd p=%0d got %b exp %b", p, update_o, exp_upd); end
            n_cmp++; if (auto_mask_o !== auto_m) begin n_err++; $display("FAIL rnd_auto p=%0d got %h exp %h", p, auto_mask_o, auto_m); end
            n_cmp++; if (mask_o !== exp_mask) begin n_err++; $display("FAIL rnd_mask p=%0d got %h exp %h", p, mask_o, exp_mask); end
            n_cmp++; if (rate_o !== exp_rate) begin n_err++; $display("FAIL rnd_rate p=%0d got %h exp %h", p, rate_o, exp_rate); end
        end
        tog31 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_exceed_holdoff();
        test_wrap_coincidence();
        test_saturation();
        test_auto_en_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
